// File: rtl/aes_key_expand_pkg.sv
// Shared AES definitions: round count, key-schedule FSM states, S-box, GF(2^8) doubling.
package aes_key_expand_pkg;

  localparam int NR_AES = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } key_state_e;

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo the AES polynomial; advances Rcon each round.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// One combinational AES-128 key-schedule step: previous round key + Rcon -> next round key.
module aes_key_round
  import aes_key_expand_pkg::*;
(
  input  logic [127:0] prev,
  input  logic [7:0]   rcon,
  output logic [127:0] next
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, temp_w;
  logic [31:0] n0, n1, n2, n3;

  // w0 is the most significant word, matching FIPS-197 byte order of the key.
  assign w0 = prev[127:96];
  assign w1 = prev[95:64];
  assign w2 = prev[63:32];
  assign w3 = prev[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign sub_w[8*gi +: 8] = AES_SBOX[rot_w[8*gi +: 8]];
  end

  assign temp_w = sub_w ^ {rcon, 24'h000000};

  // Each new word depends on the one just produced, forming a ripple chain.
  assign n0 = w0 ^ temp_w;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key expansion: one round key per cycle into a full schedule register.
module aes_key_expand #(
  parameter int NR_AES = aes_key_expand_pkg::NR_AES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [127:0]                  key,
  output logic                          busy,
  output logic                          done,
  output logic                          valid,
  output logic [128*(NR_AES+1)-1:0]     expandedKey
);
  import aes_key_expand_pkg::*;

  key_state_e   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;
  logic [127:0] slot_q [NR_AES+1];
  logic [127:0] slot_d [NR_AES+1];

  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic         accept;
  logic         last_round;

  assign accept     = (state_q == ST_IDLE) && start;
  assign last_round = (cnt_q == 4'(NR_AES));

  // Select the round key that feeds this cycle's step (slot cnt-1).
  always_comb begin
    prev_key = slot_q[0];
    for (int i = 1; i <= NR_AES; i++) begin
      if (cnt_q == 4'(i)) prev_key = slot_q[i-1];
    end
  end

  aes_key_round u_round (
    .prev (prev_key),
    .rcon (rcon_q),
    .next (next_key)
  );

  // State register plus all schedule storage; reset wins over any start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rcon_q  <= 8'h01;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i <= NR_AES; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      slot_q  <= slot_d;
    end
  end

  // Next-state: start is only looked at in IDLE; RUN leaves after writing the last slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_round) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter, Rcon, slot and status updates for load and round steps.
  always_comb begin
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    slot_d  = slot_q;
    if (accept) begin
      cnt_d     = 4'd1;
      rcon_d    = 8'h01;
      valid_d   = 1'b0;
      slot_d[0] = key;
      for (int i = 1; i <= NR_AES; i++) slot_d[i] = '0;
    end else if (state_q == ST_RUN) begin
      for (int i = 1; i <= NR_AES; i++) begin
        if (cnt_q == 4'(i)) slot_d[i] = next_key;
      end
      rcon_d = xtime(rcon_q);
      if (last_round) begin
        // Counter parks at NR_AES; it is reloaded by the next accepted start.
        valid_d = 1'b1;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Outputs: busy follows the state, done/valid come straight from their flops.
  always_comb begin
    busy  = (state_q == ST_RUN);
    done  = done_q;
    valid = valid_q;
  end

  for (genvar gi = 0; gi <= NR_AES; gi++) begin : g_pack
    assign expandedKey[128*gi +: 128] = slot_q[gi];
  end

endmodule
